// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator: S1 captures the instruction and its format,
// S2 holds the extended immediate, tag and illegal flag behind a valid/ready handshake.
module imm_gen_pipe #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned AUTO_DECODE = 1,
   parameter int unsigned TAG_W       = 5,
   parameter int unsigned ERR_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [2:0]       in_sel,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal,
   input  logic             err_clr,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [2:0] {
      FMT_I    = 3'b000,
      FMT_S    = 3'b001,
      FMT_B    = 3'b010,
      FMT_J    = 3'b011,
      FMT_U    = 3'b100,
      FMT_Z    = 3'b101,
      FMT_RSV  = 3'b110,
      FMT_ILL  = 3'b111
   } fmt_e;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   logic             v1, v2;
   logic [31:0]      s1_inst;
   fmt_e             s1_fmt;
   logic [TAG_W-1:0] s1_tag;
   logic             adv2, accept, deliver;
   fmt_e             fmt_in;
   logic [63:0]      imm_full;
   logic             imm_ill;

   assign adv2     = v1 & (~v2 | out_ready);
   assign in_ready = ~v1 | adv2;
   assign accept   = in_valid & in_ready;
   assign deliver  = v2 & out_ready;
   assign out_valid = v2;

   // Format is resolved at the input so S1 only has to carry three bits.
   always_comb begin
      fmt_in = FMT_ILL;
      if (AUTO_DECODE != 0) begin
         case (in_inst[6:0])
            OP_IMM, OP_LOAD, OP_JALR: fmt_in = FMT_I;
            OP_STORE:                 fmt_in = FMT_S;
            OP_BRANCH:                fmt_in = FMT_B;
            OP_JAL:                   fmt_in = FMT_J;
            OP_LUI, OP_AUIPC:         fmt_in = FMT_U;
            OP_SYSTEM:                fmt_in = in_inst[14] ? FMT_Z : FMT_I;
            default:                  fmt_in = FMT_ILL;
         endcase
      end else begin
         fmt_in = fmt_e'(in_sel);
      end
   end

   // Built at 64 bits and truncated, so U sign-extends only when XLEN=64.
   always_comb begin
      imm_full = '0;
      imm_ill  = 1'b0;
      case (s1_fmt)
         FMT_I: imm_full = {{52{s1_inst[31]}}, s1_inst[31:20]};
         FMT_S: imm_full = {{52{s1_inst[31]}}, s1_inst[31:25], s1_inst[11:7]};
         FMT_B: imm_full = {{51{s1_inst[31]}}, s1_inst[31], s1_inst[7],
                            s1_inst[30:25], s1_inst[11:8], 1'b0};
         FMT_J: imm_full = {{43{s1_inst[31]}}, s1_inst[31], s1_inst[19:12],
                            s1_inst[20], s1_inst[30:21], 1'b0};
         FMT_U: imm_full = {{32{s1_inst[31]}}, s1_inst[31:12], 12'b0};
         FMT_Z: imm_full = {59'b0, s1_inst[19:15]};
         default: begin
            imm_full = '0;
            imm_ill  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1      <= 1'b0;
         s1_inst <= '0;
         s1_fmt  <= FMT_I;
         s1_tag  <= '0;
      end else if (accept) begin
         v1      <= 1'b1;
         s1_inst <= in_inst;
         s1_fmt  <= fmt_in;
         s1_tag  <= in_tag;
      end else if (adv2) begin
         v1 <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2          <= 1'b0;
         out_imm     <= '0;
         out_tag     <= '0;
         out_illegal <= 1'b0;
      end else if (adv2) begin
         v2          <= 1'b1;
         out_imm     <= imm_full[XLEN-1:0];
         out_tag     <= s1_tag;
         out_illegal <= imm_ill;
      end else if (out_ready) begin
         v2 <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (err_clr) begin
         err_count <= '0;
      end else if (deliver && out_illegal && (err_count != '1)) begin
         err_count <= err_count + ERR_W'(1);
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: dut_auto (XLEN=64, opcode decode) and dut_sel (XLEN=32, explicit selector).
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid [2];
   logic        in_ready [2];
   logic [31:0] in_inst [2];
   logic [2:0]  in_sel [2];
   logic [4:0]  in_tag [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic [4:0]  out_tag [2];
   logic        out_illegal [2];
   logic        err_clr [2];
   logic [15:0] err_count [2];
   logic [63:0] out_imm0;
   logic [31:0] out_imm1;

   imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1), .TAG_W(5), .ERR_W(16)) dut_auto (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_inst(in_inst[0]),
      .in_sel(in_sel[0]), .in_tag(in_tag[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_imm(out_imm0),
      .out_tag(out_tag[0]), .out_illegal(out_illegal[0]),
      .err_clr(err_clr[0]), .err_count(err_count[0])
   );

   imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0), .TAG_W(5), .ERR_W(16)) dut_sel (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_inst(in_inst[1]),
      .in_sel(in_sel[1]), .in_tag(in_tag[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_imm(out_imm1),
      .out_tag(out_tag[1]), .out_illegal(out_illegal[1]),
      .err_clr(err_clr[1]), .err_count(err_count[1])
   );

   typedef struct {
      logic [63:0] imm;
      logic [4:0]  tag;
      logic        ill;
      int          cyc;
      bit          lat;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Auto-decode vectors with hand-computed XLEN=64 immediates.
   logic [31:0] va_inst [12] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h800002B7,
                                 32'h0000D073, 32'h0000000B, 32'h008000EF, 32'h12345017,
                                 32'hFFC12083, 32'h30002573, 32'h000080E7, 32'hFF9FF06F};
   logic [63:0] va_imm [12]  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                                 64'hFFFFFFFF80000000, 64'h1, 64'h0, 64'h8, 64'h12345000,
                                 64'hFFFFFFFFFFFFFFFC, 64'h300, 64'h0, 64'hFFFFFFFFFFFFFFF8};
   logic        va_ill [12]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};

   // Explicit-selector vectors with XLEN=32 immediates.
   logic [31:0] vb_inst [10] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'hFF9FF06F,
                                 32'h800002B7, 32'h000F8000, 32'h0000D073, 32'hFFF00093,
                                 32'h0000000B, 32'h008000EF};
   logic [2:0]  vb_sel [10]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd6, 3'd0, 3'd3};
   logic [63:0] vb_imm [10]  = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'hFFFFFFF8, 64'hFFFFFFF8,
                                 64'h80000000, 64'h1F, 64'h0, 64'h0, 64'h0, 64'h8};
   logic        vb_ill [10]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] imm_of(input int d);
      return (d == 0) ? out_imm0 : {32'h0, out_imm1};
   endfunction

   task automatic mon_pop(input int d);
      exp_t e;
      int   sz;
      sz = (d == 0) ? sb0.size() : sb1.size();
      if (sz == 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL unexpected_output dut%0d: actual tag %0d required no output", d, out_tag[d]);
         return;
      end
      if (d == 0) e = sb0.pop_front();
      else        e = sb1.pop_front();
      chk($sformatf("imm dut%0d tag%0d", d, e.tag), imm_of(d), e.imm);
      chk($sformatf("tag dut%0d", d), 64'(out_tag[d]), 64'(e.tag));
      chk($sformatf("illegal dut%0d tag%0d", d, e.tag), 64'(out_illegal[d]), 64'(e.ill));
      if (e.lat) chk($sformatf("latency dut%0d tag%0d", d, e.tag), 64'(cyc - e.cyc), 64'd2);
   endtask

   // Monitor: samples on the falling edge; a handshake seen here completes on the next rising edge.
   logic        hold [2];
   logic [63:0] hold_imm [2];
   logic [4:0]  hold_tag [2];
   initial begin
      hold[0] = 1'b0;
      hold[1] = 1'b0;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
               hold[d] = 1'b0;
            end else begin
               if (hold[d] && out_valid[d]) begin
                  chk($sformatf("stall_hold_imm dut%0d", d), imm_of(d), hold_imm[d]);
                  chk($sformatf("stall_hold_tag dut%0d", d), 64'(out_tag[d]), 64'(hold_tag[d]));
               end
               if (out_valid[d] && out_ready[d]) mon_pop(d);
               hold[d]     = out_valid[d] && !out_ready[d];
               hold_imm[d] = imm_of(d);
               hold_tag[d] = out_tag[d];
            end
         end
      end
   end

   task automatic send(input int d, input logic [31:0] inst, input logic [2:0] sel,
                       input logic [4:0] tag, input logic [63:0] imm, input logic ill,
                       input bit lat);
      exp_t e;
      bit   ok;
      ok = 1'b0;
      in_valid[d] = 1'b1;
      in_inst[d]  = inst;
      in_sel[d]   = sel;
      in_tag[d]   = tag;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge clk);
         if (in_ready[d]) begin
            ok    = 1'b1;
            e.imm = imm;
            e.tag = tag;
            e.ill = ill;
            e.cyc = cyc;
            e.lat = lat;
            if (d == 0) sb0.push_back(e);
            else        sb1.push_back(e);
         end
      end
      if (!ok) begin
         n_vec++;
         n_bad++;
         $display("FAIL accept_timeout dut%0d tag%0d: actual in_ready=0 required 1", d, tag);
      end
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
   endtask

   task automatic drain(input int d);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
         @(negedge clk);
         ok = ((d == 0) ? sb0.size() : sb1.size()) == 0;
      end
      if (!ok) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain_timeout dut%0d: actual pending entries required 0", d);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit done;
      for (int d = 0; d < 2; d++) begin
         in_valid[d]  = 1'b0;
         in_inst[d]   = '0;
         in_sel[d]    = '0;
         in_tag[d]    = '0;
         out_ready[d] = 1'b1;
         err_clr[d]   = 1'b0;
      end

      #12;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_out_valid dut%0d", d), 64'(out_valid[d]), 64'd0);
         chk($sformatf("rst_out_imm dut%0d", d), imm_of(d), 64'd0);
         chk($sformatf("rst_out_tag dut%0d", d), 64'(out_tag[d]), 64'd0);
         chk($sformatf("rst_out_illegal dut%0d", d), 64'(out_illegal[d]), 64'd0);
         chk($sformatf("rst_err_count dut%0d", d), 64'(err_count[d]), 64'd0);
      end
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("in_ready_after_reset", 64'(in_ready[0]), 64'd1);

      // Directed auto-decode vectors, no stall.
      for (int i = 0; i < 12; i++) send(0, va_inst[i], 3'd0, 5'(i), va_imm[i], va_ill[i], 1'b1);
      drain(0);
      chk("err_count_after_illegal", 64'(err_count[0]), 64'd1);

      // err_clr coinciding with an illegal delivery wins.
      out_ready[0] = 1'b0;
      send(0, 32'h0000000B, 3'd0, 5'd9, 64'd0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      chk("stalled_out_valid", 64'(out_valid[0]), 64'd1);
      err_clr[0]   = 1'b1;
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      err_clr[0] = 1'b0;
      chk("err_clr_priority", 64'(err_count[0]), 64'd0);

      // Backpressure: only two entries fit while the consumer stalls.
      out_ready[0] = 1'b0;
      fork
         begin
            for (int i = 0; i < 4; i++)
               send(0, va_inst[i + 6], 3'd0, 5'(i), va_imm[i + 6], va_ill[i + 6], 1'b0);
         end
      join_none
      repeat (5) @(negedge clk);
      chk("bp_in_ready", 64'(in_ready[0]), 64'd0);
      chk("bp_accepted", 64'(sb0.size()), 64'd2);
      @(posedge clk);
      #1;
      out_ready[0] = 1'b1;
      wait fork;
      drain(0);

      // Full-rate stream.
      for (int i = 0; i < 16; i++)
         send(0, va_inst[i % 12], 3'd0, 5'(i + 16), va_imm[i % 12], va_ill[i % 12], 1'b1);
      drain(0);
      chk("err_count_after_stream", 64'(err_count[0]), 64'd1);

      // Random consumer backpressure.
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 16; i++)
               send(0, va_inst[(i * 5) % 12], 3'd0, 5'(i), va_imm[(i * 5) % 12],
                    va_ill[(i * 5) % 12], 1'b0);
            done = 1'b1;
         end
      join_none
      for (int c = 0; c < 600 && !(done && sb0.size() == 0); c++) begin
         @(posedge clk);
         #1;
         out_ready[0] = 1'($urandom_range(0, 1));
      end
      out_ready[0] = 1'b1;
      wait fork;
      drain(0);
      chk("err_count_after_random", 64'(err_count[0]), 64'd3);

      // Explicit-selector instance.
      for (int i = 0; i < 10; i++)
         send(1, vb_inst[i], vb_sel[i], 5'(i), vb_imm[i], vb_ill[i], 1'b1);
      drain(1);
      chk("err_count_sel", 64'(err_count[1]), 64'd2);

      // Asynchronous reset with both stages full.
      out_ready[0] = 1'b0;
      send(0, va_inst[0], 3'd0, 5'd20, va_imm[0], va_ill[0], 1'b0);
      send(0, va_inst[1], 3'd0, 5'd21, va_imm[1], va_ill[1], 1'b0);
      chk("full_before_reset", 64'(out_valid[0]), 64'd1);
      #2;
      rst_n = 1'b0;
      sb0.delete();
      #1;
      chk("async_rst_out_valid", 64'(out_valid[0]), 64'd0);
      chk("async_rst_err_count", 64'(err_count[0]), 64'd0);
      chk("async_rst_out_tag", 64'(out_tag[0]), 64'd0);
      #4;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready[0] = 1'b1;
      send(0, va_inst[3], 3'd0, 5'd7, va_imm[3], va_ill[3], 1'b1);
      drain(0);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      n_bad++;
      $display("FAIL watchdog: actual still running required finished");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
